// File: rtl/read_scan_ctrl_pkg.sv
// Shared types and sizing helpers for the read-scan controller.
// Walks a row mask one word line at a time and gathers the sampled mux outputs.
package read_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_SETTLE = 1;

  // Settle counter width; never narrower than one bit so SETTLE=0 still has a register.
  function automatic int cnt_w(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/read_scan_ctrl_lsb_onehot.sv
// Lowest-set-bit isolate: picks the next row to read and the bit to clear from the pending mask.
module lsb_onehot #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_iso,
  output logic         o_zero
);

  logic [W-1:0] w_neg;

  assign w_neg  = ~i_x + 1'b1;
  assign o_iso  = i_x & w_neg;
  assign o_zero = ~|i_x;

endmodule

// File: rtl/read_scan_ctrl.sv
// Read sequencer: drives one word line per selected row, waits SETTLE cycles,
// samples dout and returns the gathered bits over a valid/ready response.
module read_scan_ctrl
  import read_scan_ctrl_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ROWS-1:0] req_mask,
  output logic [ROWS-1:0] rwl,
  input  logic            dout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ROWS-1:0] rsp_data,
  output logic            busy
);

  localparam int            CW       = cnt_w(SETTLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE);

  state_e          r_state;
  logic [ROWS-1:0] r_pend;
  logic [ROWS-1:0] r_data;
  logic [CW-1:0]   r_cnt;

  logic [ROWS-1:0] w_row;
  logic            w_zero;

  lsb_onehot #(.W(ROWS)) u_lsb (
    .i_x   (r_pend),
    .o_iso (w_row),
    .o_zero(w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_pend  <= req_mask;
            r_data  <= '0;
            r_cnt   <= '0;
            r_state <= (|req_mask) ? ST_DRIVE : ST_DONE;
          end
        end
        ST_DRIVE: begin
          if (w_zero) begin
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_data  <= (r_data & ~w_row) | (dout ? w_row : '0);
            r_pend  <= r_pend & ~w_row;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          r_cnt   <= '0;
          r_state <= w_zero ? ST_DONE : ST_DRIVE;
        end
        ST_DONE: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from the async-reset state so rwl collapses the instant rst_n falls.
  assign rwl       = (r_state == ST_DRIVE) ? w_row : '0;
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_data  = r_data;

endmodule

// File: tb/tb_read_scan_ctrl.sv
// Scoreboard bench: instance 0 runs SETTLE=1, instance 1 runs SETTLE=0, each behind a read_mux model.
module tb_read_scan_ctrl;

  localparam int              ROWS   = 4;
  localparam int              NI     = 2;
  localparam logic [ROWS-1:0] MUX_IN = 4'b1011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]           rst_n, req_valid, req_ready, dout, rsp_valid, rsp_ready, busy;
  logic [NI-1:0][ROWS-1:0] req_mask, rwl, rsp_data;

  int checks   = 0;
  int failures = 0;

  logic [ROWS-1:0] exp_q [NI][$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    read_scan_ctrl #(.ROWS(ROWS), .SETTLE(g == 0 ? 1 : 0)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_mask (req_mask[g]),
      .rwl      (rwl[g]),
      .dout     (dout[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data (rsp_data[g]),
      .busy     (busy[g])
    );
    assign dout[g] = |(rwl[g] & MUX_IN);
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int latency(input logic [ROWS-1:0] m, input int s);
    int n;
    n = $countones(m);
    return (n == 0) ? 0 : n * (s + 2);
  endfunction

  // Word line expected c cycles after the accepting edge: s+1 cycles per selected row, then one idle gap.
  function automatic logic [ROWS-1:0] exp_rwl(input logic [ROWS-1:0] m, input int s, input int c);
    int idx;
    logic [ROWS-1:0] one;
    idx = c;
    one = 1;
    for (int i = 0; i < ROWS; i++) begin
      if (m[i]) begin
        if (idx < s + 1) return one << i;
        idx -= s + 1;
        if (idx == 0) return '0;
        idx--;
      end
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  int              cnt   [NI];
  bit              track [NI];
  bit              done  [NI];
  bit              hs    [NI];
  logic [ROWS-1:0] cur_m [NI];
  logic [ROWS-1:0] held  [NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n[k]) begin
        track[k] = 0;
        done[k]  = 0;
        hs[k]    = 0;
        exp_q[k].delete();
      end else begin
        chk("rwl_onehot0", 32'($onehot0(rwl[k])), 1);
        if (hs[k]) begin
          chk("post_hs_data", rsp_data[k], held[k]);
          hs[k]   = 0;
          done[k] = 0;
        end
        if (track[k]) begin
          cnt[k]++;
          if (cnt[k] < latency(cur_m[k], settle_of(k))) begin
            chk("rwl_seq", rwl[k], exp_rwl(cur_m[k], settle_of(k), cnt[k]));
            chk("busy_ready_valid", {busy[k], req_ready[k], rsp_valid[k]}, 3'b100);
          end else begin
            chk("rsp_valid_rise", rsp_valid[k], 1);
            chk("rsp_data", rsp_data[k], cur_m[k] & MUX_IN);
            track[k] = 0;
            done[k]  = 1;
            held[k]  = cur_m[k] & MUX_IN;
          end
        end else if (done[k]) begin
          chk("done_hold", {rwl[k], rsp_valid[k], req_ready[k], busy[k], rsp_data[k]},
              {4'b0000, 3'b101, held[k]});
        end else begin
          chk("idle_outputs", {rwl[k], rsp_valid[k], busy[k], req_ready[k]}, {4'b0000, 3'b001});
        end
        if (done[k] && rsp_ready[k]) hs[k] = 1;
        if (!track[k] && !done[k] && req_valid[k] && req_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("unexpected_accept", 1, 0);
          end else begin
            cur_m[k] = exp_q[k].pop_front();
            track[k] = 1;
            cnt[k]   = -1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Caller enters at posedge+1 with instance k idle; returns just after the response handshake edge.
  task automatic run_req(input int k, input logic [ROWS-1:0] m, input int bp, input bit hold);
    int n;
    exp_q[k].push_back(m);
    req_valid[k] = 1'b1;
    req_mask[k]  = m;
    cyc();
    if (!hold) req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 200) begin
      cyc();
      n++;
    end
    if (!rsp_valid[k]) begin
      chk("rsp_timeout", 0, 1);
      req_valid[k] = 1'b0;
      return;
    end
    repeat (bp) begin
      cyc();
      if (hold) chk("bp_no_accept", {req_ready[k], rsp_valid[k], rsp_data[k]}, {2'b01, m & MUX_IN});
    end
    rsp_ready[k] = 1'b1;
    cyc();
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b0;
    chk("hs_back_to_idle", {req_ready[k], rsp_valid[k], busy[k]}, 3'b100);
  endtask

  initial begin
    int n;
    rst_n     = '0;
    req_valid = '0;
    rsp_ready = '0;
    req_mask  = '0;
    repeat (3) cyc();
    for (int k = 0; k < NI; k++)
      chk("reset_held", {rwl[k], rsp_valid[k], rsp_data[k], busy[k], req_ready[k]},
          {4'b0000, 1'b0, 4'b0000, 2'b01});
    rst_n = '1;
    cyc();
    for (int k = 0; k < NI; k++)
      chk("reset_release", {rwl[k], rsp_valid[k], rsp_data[k], busy[k], req_ready[k]},
          {4'b0000, 1'b0, 4'b0000, 2'b01});

    run_req(0, 4'b1111, 0, 0);
    run_req(0, 4'b0101, 0, 0);
    run_req(0, 4'b0000, 0, 0);
    run_req(0, 4'b1111, 5, 1);

    // Abort a scan part-way through row 2.
    exp_q[0].push_back(4'b1111);
    req_valid[0] = 1'b1;
    req_mask[0]  = 4'b1111;
    cyc();
    req_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rwl[0] != 4'b0100 && n < 50);
    chk("reach_row2", rwl[0], 4'b0100);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("async_abort", {rwl[0], rsp_valid[0], busy[0], req_ready[0]}, {4'b0000, 3'b001});
    repeat (2) cyc();
    rst_n[0] = 1'b1;
    cyc();
    run_req(0, 4'b1000, 0, 0);

    run_req(1, 4'b1111, 0, 0);
    run_req(1, 4'b0000, 1, 0);

    for (int i = 0; i < 30; i++) begin
      run_req(int'($urandom_range(0, 1)), ROWS'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) cyc();
    end

    repeat (3) cyc();
    for (int k = 0; k < NI; k++) chk("queue_drained", exp_q[k].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
